// File: rtl/encoder_ctrl_pkg.sv
// encoder_ctrl_pkg: shared types for the encoder value controller.
// Holds the handshake FSM encoding and rotation direction constants.
package encoder_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/encoder_accel_timer.sv
// encoder_accel_timer: flags fast rotation when an event follows the
// previous one in the same direction within ACCEL_GAP cycles.
module encoder_accel_timer
  import encoder_ctrl_pkg::*;
#(
  parameter int ACCEL_GAP = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic evt,
  input  logic dir,
  output logic fast
);

  localparam int CLG = $clog2(ACCEL_GAP + 1);
  localparam int CW  = (CLG < 1) ? 1 : CLG;
  localparam logic [CW-1:0] GAP = CW'(ACCEL_GAP);

  logic [CW-1:0] cnt;
  logic          last_dir;

  assign fast = (dir == last_dir) && (cnt < GAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= GAP;
      last_dir <= DIR_CCW;
    end else if (evt) begin
      cnt      <= '0;
      last_dir <= dir;
    end else if (cnt < GAP) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/encoder_value_ctrl.sv
// encoder_value_ctrl: bounded value stepped by encoder events, with a
// valid/ready publish handshake. ENCODER_VALUE_CTRL_ACCEL_EN adds acceleration.
module encoder_value_ctrl
  import encoder_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int VMIN      = 0,
  parameter int VMAX      = 100,
  parameter int VINIT     = 50,
  parameter int WRAP      = 0,
  parameter int STEP_FAST = 4,
  parameter int ACCEL_GAP = 2000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cnt,
  input  logic             i_cnt_cw,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_value,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_at_limit
);

  if (!(VMIN <= VINIT && VINIT <= VMAX &&
        longint'(VMAX) < (longint'(1) << WIDTH) &&
        STEP_FAST >= 1 && STEP_FAST <= VMAX - VMIN)) begin : g_param_err
    $error("encoder_value_ctrl: illegal parameter set");
  end

  localparam int SW = WIDTH + 2;
  typedef logic signed [SW-1:0] sval_t;

  localparam sval_t SMIN = sval_t'(VMIN);
  localparam sval_t SMAX = sval_t'(VMAX);
  localparam logic [WIDTH-1:0] UMIN  = WIDTH'(VMIN);
  localparam logic [WIDTH-1:0] UMAX  = WIDTH'(VMAX);
  localparam logic [WIDTH-1:0] UINIT = WIDTH'(VINIT);

  logic [WIDTH-1:0] value, value_d, cnt_val, ld_val;
  state_t           state, state_d;
  sval_t            cur, step, sum, lds;
  logic             fast, evt, change;

  // a load wins over a coincident event, so the timer never sees it
  assign evt = i_cnt & ~i_load;

`ifdef ENCODER_VALUE_CTRL_ACCEL_EN
  encoder_accel_timer #(
    .ACCEL_GAP(ACCEL_GAP)
  ) u_accel (
    .clk (i_clk),
    .rst (i_rst),
    .evt (evt),
    .dir (i_cnt_cw),
    .fast(fast)
  );
`else
  assign fast = 1'b0;
`endif

  always_comb begin
    cur  = $signed({2'b00, value});
    step = fast ? sval_t'(STEP_FAST) : sval_t'(1);
    sum  = (i_cnt_cw == DIR_CW) ? cur + step : cur - step;
    if (sum > SMAX)
      cnt_val = (WRAP != 0) ? UMIN : UMAX;
    else if (sum < SMIN)
      cnt_val = (WRAP != 0) ? UMAX : UMIN;
    else
      cnt_val = sum[WIDTH-1:0];
  end

  always_comb begin
    lds = $signed({2'b00, i_load_value});
    if (lds > SMAX)
      ld_val = UMAX;
    else if (lds < SMIN)
      ld_val = UMIN;
    else
      ld_val = i_load_value;
  end

  always_comb begin
    value_d = value;
    change  = 1'b0;
    if (i_load) begin
      value_d = ld_val;
      change  = 1'b1;
    end else if (i_cnt) begin
      value_d = cnt_val;
      change  = (cnt_val != value);
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (change) state_d = ST_PEND;
      ST_PEND: if (i_ready && !change) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value <= UINIT;
      state <= ST_IDLE;
    end else begin
      value <= value_d;
      state <= state_d;
    end
  end

  assign o_value    = value;
  assign o_valid    = (state == ST_PEND);
  assign o_at_limit = (value == UMIN) || (value == UMAX);

endmodule

// File: tb/tb_encoder_value_ctrl.sv
// tb_encoder_value_ctrl: directed checks of a saturating and a wrapping
// instance sharing one stimulus stream.
module tb_encoder_value_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt = 1'b0;
  logic       cw = 1'b0;
  logic       load = 1'b0;
  logic [7:0] ldv = 8'd0;
  logic       ready = 1'b1;
  logic [7:0] value0, value1;
  logic       valid0, valid1, lim0, lim1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  encoder_value_ctrl dut0 (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw),
    .i_load(load), .i_load_value(ldv), .o_value(value0),
    .o_valid(valid0), .i_ready(ready), .o_at_limit(lim0)
  );

  encoder_value_ctrl #(.WRAP(1), .ACCEL_GAP(100)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw),
    .i_load(load), .i_load_value(ldv), .o_value(value1),
    .o_valid(valid1), .i_ready(ready), .o_at_limit(lim1)
  );

  typedef struct {
    logic       cnt;
    logic       cw;
    logic       load;
    logic [7:0] ldv;
    logic       ready;
    logic [7:0] ev;
    logic       evl;
    logic       elim;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic dir);
    cnt = 1'b1;
    cw  = dir;
    @(negedge clk);
    cnt = 1'b0;
  endtask

  // reset held with a coincident event and load, both must be ignored
  task automatic do_reset();
    rst  = 1'b1;
    cnt  = 1'b1;
    load = 1'b1;
    ldv  = 8'd200;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    cnt  = 1'b0;
    load = 1'b0;
    ldv  = 8'd0;
    @(negedge clk);
  endtask

  int exp_a[3];
  int exp_b;
  int exp_c[5];

  initial begin
`ifdef ENCODER_VALUE_CTRL_ACCEL_EN
    exp_a = '{51, 55, 59};
    exp_b = 67;
    exp_c = '{51, 55, 59, 58, 57};
`else
    exp_a = '{51, 52, 53};
    exp_b = 55;
    exp_c = '{51, 52, 53, 52, 51};
`endif
    tbl[0]  = '{1, 1, 0, 0,   0, 51,  1, 0};
    tbl[1]  = '{0, 0, 0, 0,   1, 51,  0, 0};
    tbl[2]  = '{1, 0, 0, 0,   1, 50,  1, 0};
    tbl[3]  = '{0, 0, 0, 0,   0, 50,  1, 0};
    tbl[4]  = '{0, 0, 0, 0,   1, 50,  0, 0};
    tbl[5]  = '{0, 0, 1, 99,  0, 99,  1, 0};
    tbl[6]  = '{1, 1, 0, 0,   1, 100, 1, 1};
    tbl[7]  = '{1, 1, 0, 0,   1, 100, 0, 1};
    tbl[8]  = '{1, 1, 0, 0,   1, 100, 0, 1};
    tbl[9]  = '{1, 0, 1, 200, 1, 100, 1, 1};
    tbl[10] = '{0, 0, 0, 0,   1, 100, 0, 1};
    tbl[11] = '{0, 0, 1, 0,   1, 0,   1, 1};
    tbl[12] = '{1, 0, 0, 0,   1, 0,   0, 1};
    tbl[13] = '{0, 0, 1, 7,   1, 7,   1, 0};
    tbl[14] = '{1, 1, 0, 0,   0, 8,   1, 0};

    @(negedge clk);
    do_reset();
    chk("reset value0", int'(value0), 50);
    chk("reset valid0", int'(valid0), 0);
    chk("reset lim0", int'(lim0), 0);
    chk("reset value1", int'(value1), 50);
    chk("reset valid1", int'(valid1), 0);

    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat (9) @(negedge clk);
      pulse(1'b1);
      chk($sformatf("cw%0d value", k), int'(value0), exp_a[k]);
      chk($sformatf("cw%0d valid", k), int'(valid0), 1);
    end

    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse(1'b1);
      chk($sformatf("coalesce%0d valid", k), int'(valid0), 1);
      repeat (2) @(negedge clk);
    end
    chk("coalesce value", int'(value0), exp_b);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("accept valid", int'(valid0), 0);
    chk("accept value", int'(value0), exp_b);

    do_reset();
    pulse(1'b1);
    chk("pend value", int'(value0), 51);
    chk("pend valid", int'(valid0), 1);
    rst = 1'b1;
    #1;
    chk("async rst value", int'(value0), 50);
    chk("async rst valid", int'(valid0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      cnt   = tbl[i].cnt;
      cw    = tbl[i].cw;
      load  = tbl[i].load;
      ldv   = tbl[i].ldv;
      ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("row%0d value", i), int'(value0), int'(tbl[i].ev));
      chk($sformatf("row%0d valid", i), int'(valid0), int'(tbl[i].evl));
      chk($sformatf("row%0d lim", i), int'(lim0), int'(tbl[i].elim));
    end
    cnt   = 1'b0;
    load  = 1'b0;
    ready = 1'b1;
    @(negedge clk);

    load = 1'b1;
    ldv  = 8'd0;
    @(negedge clk);
    load = 1'b0;
    chk("wrap load value1", int'(value1), 0);
    pulse(1'b0);
    chk("sat ccw value0", int'(value0), 0);
    chk("sat ccw valid0", int'(valid0), 0);
    chk("wrap ccw value1", int'(value1), 100);
    chk("wrap ccw valid1", int'(valid1), 1);
    chk("wrap ccw lim1", int'(lim1), 1);
    pulse(1'b1);
    chk("sat cw value0", int'(value0), 1);
    chk("wrap cw value1", int'(value1), 0);

    do_reset();
    for (int k = 0; k < 5; k++) begin
      repeat ((k == 4) ? 149 : 19) @(negedge clk);
      pulse((k < 3) ? 1'b1 : 1'b0);
      chk($sformatf("accel%0d value1", k), int'(value1), exp_c[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoder_value_ctrl.md
ENCODER_VALUE_CTRL -- requirements
Module: encoder_value_ctrl

Interface
REQ-001 SHALL take parameter WIDTH, default 8: width of the controlled value.
REQ-002 SHALL take parameter VMIN, default 0: lower bound of the value.
REQ-003 SHALL take parameter VMAX, default 100: upper bound of the value.
REQ-004 SHALL take parameter VINIT, default 50: value after reset.
REQ-005 SHALL take parameter WRAP, default 0: 0 selects saturate at the bounds, 1 selects wrap-around.
REQ-006 SHALL take parameter STEP_FAST, default 4: step size while accelerated.
REQ-007 SHALL take parameter ACCEL_GAP, default 2000000: maximum cycles between events that still counts as fast rotation.
REQ-008 SHALL have port i_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-009 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port i_cnt, input, 1 bit: one-cycle rotation event pulse from the encoder driver.
REQ-011 SHALL have port i_cnt_cw, input, 1 bit: direction, valid with i_cnt; 1 = increment, 0 = decrement.
REQ-012 SHALL have port i_load, input, 1 bit: one-cycle request to overwrite the value.
REQ-013 SHALL have port i_load_value, input, WIDTH bits: value to load.
REQ-014 SHALL have port o_value, output, WIDTH bits: current registered value.
REQ-015 SHALL have port o_valid, output, 1 bit: changed value is pending for the consumer.
REQ-016 SHALL have port i_ready, input, 1 bit: consumer accepts o_value.
REQ-017 SHALL have port o_at_limit, output, 1 bit: high while o_value equals VMIN or VMAX.

Function
REQ-018 SHALL update o_value on the clock edge that samples i_cnt=1; the new value is visible one cycle later.
REQ-019 SHALL compute next value in signed WIDTH+2 bits as o_value ± step, with step = 1 or STEP_FAST.
REQ-020 WRAP=0: a result > VMAX SHALL clamp to VMAX; a result < VMIN SHALL clamp to VMIN.
REQ-021 WRAP=1: a result > VMAX SHALL become VMIN; a result < VMIN SHALL become VMAX; no remainder is carried.
REQ-022 i_load SHALL set o_value to i_load_value clamped to [VMIN,VMAX] and SHALL have priority over a simultaneous i_cnt, which is dropped.
REQ-023 The handshake FSM SHALL have states IDLE (o_valid=0) and PEND (o_valid=1).
REQ-024 The FSM SHALL go IDLE->PEND on any load or event that changes o_value; an event leaving o_value unchanged (saturated) SHALL NOT raise o_valid.
REQ-025 The FSM SHALL go PEND->IDLE on o_valid&i_ready unless a value change occurs in the same cycle, in which case it stays in PEND.
REQ-026 Events arriving in PEND SHALL coalesce into o_value; no event SHALL be lost or queued.
REQ-027 o_at_limit SHALL be a combinational compare of o_value.

Reset
REQ-028 i_rst SHALL asynchronously force o_value=VINIT, FSM=IDLE (o_valid=0), gap counter=ACCEL_GAP, last-direction=0, and o_at_limit follows VINIT.
REQ-029 An event or load coincident with i_rst SHALL be ignored.

Configuration
REQ-030 With ENCODER_VALUE_CTRL_ACCEL_EN defined: a gap counter SHALL count cycles since the last event, saturating at ACCEL_GAP and clearing on each event; step = STEP_FAST when the event direction equals the last direction and the counter < ACCEL_GAP, else 1.
REQ-031 Without ENCODER_VALUE_CTRL_ACCEL_EN: step SHALL always be 1, and the gap counter and last-direction registers SHALL be absent.

Structure
REQ-032 Package encoder_ctrl_pkg SHALL hold the FSM state enum and the CW/CCW direction constants.
REQ-033 Acceleration logic SHALL be the sub-module encoder_accel_timer (in: event, dir; out: fast), instantiated only under the macro.
REQ-034 Elaboration SHALL fail unless VMIN <= VINIT <= VMAX < 2^WIDTH and 1 <= STEP_FAST <= VMAX-VMIN.

Verification
REQ-035 Reset, then 3 CW pulses 10 cycles apart (ACCEL off) -> o_value 50->51->52->53, each one cycle after its pulse.
REQ-036 WRAP=0, value 99, two CW pulses -> 100, then 100 with o_valid not re-raised after acceptance; o_at_limit=1.
REQ-037 WRAP=1, value 0, one CCW pulse -> 100; then one CW pulse -> 0.
REQ-038 i_ready held 0, 5 CW pulses -> o_valid stays 1, o_value=55; i_ready=1 for one cycle -> o_valid=0.
REQ-039 ACCEL on with ACCEL_GAP=100, CW pulses 20 cycles apart -> steps 1,4,4; a CCW pulse -> step 1; a 150-cycle gap -> step 1.
REQ-040 i_load=1 with i_load_value=200 coincident with i_cnt -> o_value=100, o_valid=1, event dropped; i_rst mid-PEND -> o_value=50, o_valid=0 immediately.
